mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_req_fsm.sv | 58 +++++
 rtl/mem_stage.sv | 98 +++++++++
 tb/tb_mem_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM state type and MEM/WB payload for the memory-access stage.
package mem_stage_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned REG_SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0]    wb_data;
    logic [WORD_W-1:0]    pc_2;
    logic [REG_SEL_W-1:0] sel;
    logic                 reg_write;
    logic                 not_halt;
    logic                 err;
  } mem_wb_t;

  // A bubble writes nothing and keeps the machine running.
  localparam mem_wb_t MEM_WB_BUBBLE = '{
    wb_data:   WORD_W'(0),
    pc_2:      WORD_W'(0),
    sel:       REG_SEL_W'(0),
    reg_write: 1'b0,
    not_halt:  1'b1,
    err:       1'b0
  };

endpackage

// File: rtl/mem_req_fsm.sv
// Request/done handshake tracker: drives the memory strobes and the pipeline stall,
// and flags the cycle in which the outstanding access completes.
module mem_req_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic is_write,
  input  logic mem_busy,
  input  logic mem_done,
  output logic rd_c,
  output logic wr_c,
  output logic stall_c,
  output logic complete_c
);

  state_t state;

  // Only an accepted request that did not finish in the same cycle waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (mem_op && !mem_busy && !mem_done) state <= WAIT;
        WAIT:    if (mem_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are held while the memory is busy; reset silences everything.
  always_comb begin
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    stall_c    = 1'b0;
    complete_c = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            rd_c       = !is_write;
            wr_c       = is_write;
            complete_c = !mem_busy && mem_done;
            stall_c    = !complete_c;
          end
        end
        WAIT: begin
          complete_c = mem_done;
          stall_c    = !mem_done;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage with MEM/WB register. Optional misaligned-address
// trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_W-1:0]    ALURes_EX_MEM,
  input  logic [WORD_W-1:0]    rdData2_EX_MEM,
  input  logic [WORD_W-1:0]    PC_2_EX_MEM,
  input  logic                 isNotHalt_EX_MEM,
  input  logic                 isMemToReg_EX_MEM,
  input  logic                 isMemRead_EX_MEM,
  input  logic                 isMemWrite_EX_MEM,
  input  logic                 isRegWrite_EX_MEM,
  input  logic [REG_SEL_W-1:0] writeRegSel_EX_MEM,
  output logic [WORD_W-1:0]    mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  output logic                 mem_rd,
  output logic                 mem_wr,
  input  logic                 mem_busy,
  input  logic                 mem_done,
  input  logic [WORD_W-1:0]    mem_rdata,
  output logic                 memStall,
  output logic [WORD_W-1:0]    wbData_MEM_WB,
  output logic [WORD_W-1:0]    PC_2_MEM_WB,
  output logic [REG_SEL_W-1:0] writeRegSel_MEM_WB,
  output logic                 isRegWrite_MEM_WB,
  output logic                 isNotHalt_MEM_WB,
  output logic                 err_MEM_WB
);

  logic    mem_op_c;
  logic    misaligned_c;
  logic    req_c;
  logic    rd_c;
  logic    wr_c;
  logic    stall_c;
  logic    complete_c;
  mem_wb_t mem_wb;
  mem_wb_t mem_wb_next_c;

  assign mem_op_c = isMemRead_EX_MEM | isMemWrite_EX_MEM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_c = mem_op_c & ALURes_EX_MEM[0];
`else
  assign misaligned_c = 1'b0;
`endif

  // A trapped access never reaches memory.
  assign req_c = mem_op_c & ~misaligned_c;

  mem_req_fsm u_req_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (req_c),
    .is_write   (isMemWrite_EX_MEM),
    .mem_busy   (mem_busy),
    .mem_done   (mem_done),
    .rd_c       (rd_c),
    .wr_c       (wr_c),
    .stall_c    (stall_c),
    .complete_c (complete_c)
  );

  assign mem_rd    = rd_c;
  assign mem_wr    = wr_c;
  assign memStall  = stall_c;
  assign mem_addr  = ALURes_EX_MEM;
  assign mem_wdata = rdData2_EX_MEM;

  // Instruction leaves MEM when it needs no access or its access completes now.
  always_comb begin
    mem_wb_next_c = MEM_WB_BUBBLE;
    if (!req_c || complete_c) begin
      mem_wb_next_c.wb_data   = isMemToReg_EX_MEM ? mem_rdata : ALURes_EX_MEM;
      mem_wb_next_c.pc_2      = PC_2_EX_MEM;
      mem_wb_next_c.sel       = writeRegSel_EX_MEM;
      mem_wb_next_c.reg_write = isRegWrite_EX_MEM & ~misaligned_c;
      mem_wb_next_c.not_halt  = isNotHalt_EX_MEM & ~misaligned_c;
      mem_wb_next_c.err       = misaligned_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_wb <= MEM_WB_BUBBLE;
    else     mem_wb <= mem_wb_next_c;
  end

  assign wbData_MEM_WB      = mem_wb.wb_data;
  assign PC_2_MEM_WB        = mem_wb.pc_2;
  assign writeRegSel_MEM_WB = mem_wb.sel;
  assign isRegWrite_MEM_WB  = mem_wb.reg_write;
  assign isNotHalt_MEM_WB   = mem_wb.not_halt;
  assign err_MEM_WB         = mem_wb.err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver plays EX/MEM and the data memory and
// queues the expected MEM/WB contents; a monitor pops and compares each cycle.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_res, rd_data2, pc_2;
  logic        not_halt, mem_to_reg, mem_read, mem_write, reg_write;
  logic [2:0]  sel;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_busy, mem_done, mem_stall;
  logic [15:0] wb_data, wb_pc;
  logic [2:0]  wb_sel;
  logic        wb_rw, wb_nh, wb_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] pc;
    logic [2:0]  sel;
    logic        rw;
    logic        nh;
    logic        err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .ALURes_EX_MEM      (alu_res),
    .rdData2_EX_MEM     (rd_data2),
    .PC_2_EX_MEM        (pc_2),
    .isNotHalt_EX_MEM   (not_halt),
    .isMemToReg_EX_MEM  (mem_to_reg),
    .isMemRead_EX_MEM   (mem_read),
    .isMemWrite_EX_MEM  (mem_write),
    .isRegWrite_EX_MEM  (reg_write),
    .writeRegSel_EX_MEM (sel),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rd             (mem_rd),
    .mem_wr             (mem_wr),
    .mem_busy           (mem_busy),
    .mem_done           (mem_done),
    .mem_rdata          (mem_rdata),
    .memStall           (mem_stall),
    .wbData_MEM_WB      (wb_data),
    .PC_2_MEM_WB        (wb_pc),
    .writeRegSel_MEM_WB (wb_sel),
    .isRegWrite_MEM_WB  (wb_rw),
    .isNotHalt_MEM_WB   (wb_nh),
    .err_MEM_WB         (wb_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each entry becomes visible one edge after the cycle that produced it.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #2;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("wbData", wb_data, e.data);
      check("PC_2", wb_pc, e.pc);
      check("writeRegSel", 16'(wb_sel), 16'(e.sel));
      check("isRegWrite", 16'(wb_rw), 16'(e.rw));
      check("isNotHalt", 16'(wb_nh), 16'(e.nh));
      check("err", 16'(wb_err), 16'(e.err));
    end
  end

  task automatic set_exmem(input logic rd, input logic wr, input logic m2r, input logic rw,
                           input logic nh, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] pc, input logic [2:0] s);
    mem_read = rd; mem_write = wr; mem_to_reg = m2r; reg_write = rw;
    not_halt = nh; alu_res = addr; rd_data2 = wdata; pc_2 = pc; sel = s;
  endtask

  // One instruction through MEM: busy cycles, then request, then done lat cycles later.
  task automatic run(input logic rd, input logic wr, input logic m2r, input logic rw,
                     input logic nh, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] pc, input logic [15:0] rdata, input logic [2:0] s,
                     input int busy_in, input int lat_in, input bit stray);
    bit   memop, mis, access, strobe;
    int   busy, lat, total;
    exp_t e;
    memop = rd | wr;
    mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = memop && addr[0];
`endif
    access = memop && !mis;
    busy   = access ? busy_in : 0;
    lat    = access ? lat_in : 0;
    total  = busy + lat;
    for (int c = 0; c <= total; c++) begin
      @(posedge clk);
      #1;
      set_exmem(rd, wr, m2r, rw, nh, addr, wdata, pc, s);
      mem_busy  = access && (c < busy);
      mem_done  = access ? (c == total) : stray;
      mem_rdata = (c == total) ? rdata : 16'($urandom);
      e.due = cyc + 1;
      if (c < total) begin
        e.data = '0; e.pc = '0; e.sel = '0; e.rw = 1'b0; e.nh = 1'b1; e.err = 1'b0;
      end else begin
        e.data = m2r ? rdata : addr;
        e.pc   = pc;
        e.sel  = s;
        e.rw   = rw && !mis;
        e.nh   = nh && !mis;
        e.err  = mis;
      end
      q.push_back(e);
      @(negedge clk);
      strobe = access && (c <= busy);
      check("memStall", 16'(mem_stall), 16'(c < total));
      check("mem_rd", 16'(mem_rd), 16'(strobe && !wr));
      check("mem_wr", 16'(mem_wr), 16'(strobe && wr));
      if (strobe) begin
        check("mem_addr", mem_addr, addr);
        if (wr) check("mem_wdata", mem_wdata, wdata);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memStall"}, 16'(mem_stall), 16'(0));
    check({tag, "_mem_rd"}, 16'(mem_rd), 16'(0));
    check({tag, "_mem_wr"}, 16'(mem_wr), 16'(0));
    check({tag, "_wbData"}, wb_data, 16'h0000);
    check({tag, "_PC_2"}, wb_pc, 16'h0000);
    check({tag, "_sel"}, 16'(wb_sel), 16'(0));
    check({tag, "_isRegWrite"}, 16'(wb_rw), 16'(0));
    check({tag, "_isNotHalt"}, 16'(wb_nh), 16'(1));
    check({tag, "_err"}, 16'(wb_err), 16'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int kind;
    logic rd, wr, m2r;
    rst = 1'b1;
    set_exmem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
    mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0;
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1 rst = 1'b0;

    // Directed cases.
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0, 16'h0102, 16'h5555, 3'd5, 0, 0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0, 16'h0104, 16'hBEEF, 3'd2, 0, 0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0042, 16'h0, 16'h0106, 16'hCAFE, 3'd3, 0, 3, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0080, 16'hA5A5, 16'h0108, 16'h0, 3'd1, 2, 0, 1'b0);
    run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0090, 16'h5A5A, 16'h010A, 16'h0, 3'd4, 1, 1, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0, 16'h010C, 16'h7777, 3'd6, 0, 2, 1'b0);

    // Reset while an access is outstanding.
    @(posedge clk); #1;
    set_exmem(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0, 16'h0200, 3'd7);
    mem_busy = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    check("rw_req_rd", 16'(mem_rd), 16'(1));
    check("rw_req_stall", 16'(mem_stall), 16'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_wait_rd", 16'(mem_rd), 16'(0));
    check("rw_wait_stall", 16'(mem_stall), 16'(1));
    #1 rst = 1'b1;
    q.delete();
    #1;
    check_reset_outputs("rst_wait");
    @(posedge clk); #1;
    set_exmem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
    @(posedge clk); #1 rst = 1'b0;
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4321, 16'h0, 16'h0300, 16'h9999, 3'd3, 0, 0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 16'h0, 16'h0302, 16'h0, 3'd2, 0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 3);
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      m2r  = (kind == 1) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      run(rd, wr, m2r, 1'($urandom), 1'($urandom_range(0, 7) != 0),
          16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom));
    end

    @(posedge clk); #1;
    set_exmem(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 3'd0);
    mem_busy = 1'b0; mem_done = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("drain", 16'(q.size()), 16'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
